// File: rtl/ro_trng_collector_pkg.sv
// ---------------------------------------------------------------------------
// ro_trng_collector_pkg
// Shared definitions for the ring-oscillator TRNG collector:
//   - default parameter values for the collector top level
//   - von Neumann debias FSM state encoding
// No ports (package).
// ---------------------------------------------------------------------------
package ro_trng_collector_pkg;

  localparam int unsigned N_CH_DEF      = 4;
  localparam int unsigned W_DEF         = 8;
  localparam int unsigned DIV_W_DEF     = 8;
  localparam int unsigned REP_LIMIT_DEF = 32;

  // ST_IDLE: waiting for the first bit of a pair.
  // ST_HAVE_FIRST: first bit stored, the next sample completes the pair.
  typedef enum logic [0:0] {
    ST_IDLE       = 1'b0,
    ST_HAVE_FIRST = 1'b1
  } vn_state_e;

endpackage : ro_trng_collector_pkg

// File: rtl/ro_trng_collector_vn_debias.sv
// ---------------------------------------------------------------------------
// ro_trng_collector_vn_debias
// Von Neumann debiaser. It consumes one raw bit per tick and emits at most one
// accepted bit per pair: (0,1) -> 0, (1,0) -> 1, and equal pairs are dropped.
// When debiasing is disabled, every ticked raw bit passes straight through.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clr_i          synchronous clear of the pair state (collector disabled)
//   tick_i         sample strobe, one cycle wide
//   r_i            raw bit for this tick
//   debias_en_i    1 = pairwise debiasing, 0 = pass-through
//   bit_valid_o    combinational: an accepted bit is present this cycle
//   bit_o          the accepted bit
// ---------------------------------------------------------------------------
module ro_trng_collector_vn_debias
  import ro_trng_collector_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic tick_i,
  input  logic r_i,
  input  logic debias_en_i,
  output logic bit_valid_o,
  output logic bit_o
);

  vn_state_e state_q, state_d;
  logic      first_q, first_d;
  logic      den_q;
  vn_state_e st_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
      den_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      den_q   <= debias_en_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    bit_valid_o = 1'b0;
    bit_o       = 1'b0;
    // A mode change discards any half-collected pair so that a pair never
    // spans bits collected under different modes.
    st_eff      = (debias_en_i != den_q) ? ST_IDLE : state_q;

    if (clr_i) begin
      state_d = ST_IDLE;
      first_d = 1'b0;
    end else if (!debias_en_i) begin
      state_d     = ST_IDLE;
      bit_valid_o = tick_i;
      bit_o       = r_i;
    end else begin
      state_d = st_eff;
      if (tick_i) begin
        unique case (st_eff)
          ST_IDLE: begin
            first_d = r_i;
            state_d = ST_HAVE_FIRST;
          end
          ST_HAVE_FIRST: begin
            // The first bit of an unequal pair is the output bit.
            if (first_q != r_i) begin
              bit_valid_o = 1'b1;
              bit_o       = first_q;
            end
            state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

endmodule : ro_trng_collector_vn_debias

// File: rtl/ro_trng_collector.sv
// ---------------------------------------------------------------------------
// ro_trng_collector
// Collects entropy from N_CH free-running ring oscillators. The synchronised
// oscillator bits that ch_mask selects are XOR-folded into one raw bit. That
// raw bit is sampled every max(div,1) clocks and health-checked with a
// repetition count. It is then optionally von Neumann debiased and packed
// LSB-first into W-bit words, which leave on a valid/ready port.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en            collector enable; low clears the collection state and flags
//   ro_bits       raw oscillator outputs, asynchronous to clk
//   ch_mask       1 = channel participates in the XOR
//   div           sample period in clocks (0 behaves as 1)
//   debias_en     1 = von Neumann debiasing
//   out_data      packed word, first accepted bit in bit 0
//   out_valid     out_data holds a word not yet transferred
//   out_ready     consumer accepts out_data when out_valid is high
//   health_fail   sticky repetition-count failure
//   overrun       sticky: an accepted bit was dropped for lack of space
// ---------------------------------------------------------------------------
module ro_trng_collector
  import ro_trng_collector_pkg::*;
#(
  parameter int unsigned N_CH      = N_CH_DEF,
  parameter int unsigned W         = W_DEF,
  parameter int unsigned DIV_W     = DIV_W_DEF,
  parameter int unsigned REP_LIMIT = REP_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_CH-1:0]  ro_bits,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic [DIV_W-1:0] div,
  input  logic             debias_en,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             health_fail,
  output logic             overrun
);

  localparam int CNT_W = $clog2(W + 1);
  localparam int RUN_W = $clog2(REP_LIMIT + 1);

  // Run length after one more identical sample, held at REP_LIMIT.
  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] v);
    if (v >= RUN_W'(REP_LIMIT)) return RUN_W'(REP_LIMIT);
    return v + RUN_W'(1);
  endfunction

  // Terminal divider count for a requested period; a period of 0 means 1.
  function automatic logic [DIV_W-1:0] div_last(input logic [DIV_W-1:0] d);
    if (d == '0) return '0;
    return d - DIV_W'(1);
  endfunction

  // Synchroniser: the only logic that ever sees ro_bits.
  logic [N_CH-1:0] sync1_q, sync2_q;

  // Divider
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] lim_q, lim_d;
  logic             tick;

  // Raw bit and health test
  logic             r;
  logic             prev_r_q, prev_r_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             hf_q, hf_d;

  // Debias output
  logic             bit_valid;
  logic             bit_out;

  // Packer and output port
  logic [W-1:0]     sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
  logic [W-1:0]     word;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             ovr_q, ovr_d;
  logic             acc, xfer, load;

  // ---- stage: synchronise -------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ro_bits;
      sync2_q <= sync1_q;
    end
  end

  // ---- stage: sample divider and raw bit ----------------------------------
  always_comb begin
    // The period is captured at the start of every count sequence, so a new
    // div only takes effect once the current period has wrapped.
    lim_d     = (div_cnt_q == '0) ? div_last(div) : lim_q;
    tick      = en && (div_cnt_q == lim_d);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    if (!en) begin
      div_cnt_d = '0;
      lim_d     = '0;
    end
  end

  assign r = ^(sync2_q & ch_mask);

  // ---- stage: repetition-count health test --------------------------------
  always_comb begin
    prev_r_d = prev_r_q;
    run_d    = run_q;
    hf_d     = hf_q;
    if (!en) begin
      run_d = '0;
      hf_d  = 1'b0;
    end else if (tick) begin
      prev_r_d = r;
      // run_q == 0 means no sample yet, so the first sample starts a run of 1.
      if ((run_q != '0) && (r == prev_r_q)) run_d = run_sat_inc(run_q);
      else                                  run_d = RUN_W'(1);
      if (run_d == RUN_W'(REP_LIMIT)) hf_d = 1'b1;
    end
  end

  // ---- stage: von Neumann debias ------------------------------------------
  ro_trng_collector_vn_debias u_vn_debias (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (~en),
    .tick_i      (tick),
    .r_i         (r),
    .debias_en_i (debias_en),
    .bit_valid_o (bit_valid),
    .bit_o       (bit_out)
  );

  // ---- stage: pack and output handshake -----------------------------------
  always_comb begin
    acc   = bit_valid && !hf_q;
    xfer  = out_valid_q && out_ready;
    word  = sh_q;
    cnt_n = cnt_q;
    ovr_d = ovr_q;

    if (cnt_q == CNT_W'(W)) begin
      // A full word is parked waiting for the output; new bits are lost.
      if (acc) ovr_d = 1'b1;
    end else if (acc) begin
      word  = sh_q | (W'(bit_out) << cnt_q);
      cnt_n = cnt_q + CNT_W'(1);
    end

    // The bit that completes a word is merged combinationally so the word
    // reaches out_data on the same edge that accepts its last bit.
    load = en && !hf_q && (cnt_n == CNT_W'(W)) && (!out_valid_q || xfer);

    sh_d        = load ? '0 : word;
    cnt_d       = load ? '0 : cnt_n;
    out_data_d  = load ? word : out_data_q;
    out_valid_d = load || (out_valid_q && !xfer);

    if (!en) begin
      sh_d  = '0;
      cnt_d = '0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      lim_q       <= '0;
      prev_r_q    <= 1'b0;
      run_q       <= '0;
      hf_q        <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      lim_q       <= lim_d;
      prev_r_q    <= prev_r_d;
      run_q       <= run_d;
      hf_q        <= hf_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign health_fail = hf_q;
  assign overrun     = ovr_q;

endmodule : ro_trng_collector

// File: tb/tb_ro_trng_collector.sv
// ---------------------------------------------------------------------------
// tb_ro_trng_collector
// Scoreboard bench for ro_trng_collector (N_CH=4, W=8, DIV_W=8, REP_LIMIT=32).
// Inputs are driven on the falling edge. A raw bit driven before rising edge k
// is sampled by the tick on edge k+2, after the 2-flop synchroniser. Each
// stream holds en low for its first two cycles so that the first tick sees
// st[0].
// ---------------------------------------------------------------------------
module tb_ro_trng_collector;

  localparam int N_CH  = 4;
  localparam int W     = 8;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [N_CH-1:0]  ro_bits;
  logic [N_CH-1:0]  ch_mask;
  logic [DIV_W-1:0] div;
  logic             debias_en;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic             health_fail;
  logic             overrun;

  always #5 clk = ~clk;

  ro_trng_collector #(.N_CH(N_CH), .W(W), .DIV_W(DIV_W), .REP_LIMIT(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .ro_bits     (ro_bits),
    .ch_mask     (ch_mask),
    .div         (div),
    .debias_en   (debias_en),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .health_fail (health_fail),
    .overrun     (overrun)
  );

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [W-1:0] sb[$];
  bit         st[64];
  int         use_rand;
  logic       pv, px;
  logic [W-1:0] pd;
  int         stab_err;
  int         first_vld, last_vld, first_hf, first_ovr;
  logic [W-1:0] exp_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Oscillator vector whose masked XOR equals b.
  function automatic logic [N_CH-1:0] mk_ro(input bit b);
    logic [N_CH-1:0] v;
    logic done;
    if (use_rand == 0) return {{(N_CH-1){1'b0}}, b};
    v    = N_CH'($urandom);
    done = 1'b0;
    if ((^(v & ch_mask)) != b)
      for (int i = 0; i < N_CH; i++)
        if (ch_mask[i] && !done) begin
          v[i] = ~v[i];
          done = 1'b1;
        end
    return v;
  endfunction

  // One clock of stimulus; the handshake on the coming edge is scored here.
  task automatic drive(input logic [N_CH-1:0] ro, input logic e, input logic rdy);
    logic x;
    @(negedge clk);
    if (pv && !px && (out_valid !== 1'b1 || out_data !== pd)) stab_err++;
    ro_bits   = ro;
    en        = e;
    out_ready = rdy;
    x = out_valid && out_ready;
    if (x) begin
      if (sb.size() == 0) chk("sb_extra_word", sb.size(), 1);
      else                chk("sb_word", out_data, sb.pop_front());
    end
    pv = out_valid;
    pd = out_data;
    px = x;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(mk_ro(1'b0), 1'b0, 1'b1);
  endtask

  // rdy_pulse: -1 = always ready, -2 = never ready, else ready only at that call.
  task automatic stream(input int n, input int ncyc, input int rdy_pulse);
    logic rdy;
    first_vld = -1; last_vld = -1; first_hf = -1; first_ovr = -1;
    for (int i = 0; i < ncyc; i++) begin
      rdy = (rdy_pulse == -1) ? 1'b1 : (rdy_pulse == i);
      drive(mk_ro(st[(i < n) ? i : n - 1]), (i >= 2), rdy);
      if (out_valid && first_vld < 0)   first_vld = i;
      if (out_valid)                    last_vld  = i;
      if (health_fail && first_hf < 0)  first_hf  = i;
      if (overrun && first_ovr < 0)     first_ovr = i;
    end
  endtask

  // Reference: nt ticks over st (last value held), debias, LSB-first packing.
  task automatic ref_push(input int nt, input int n, input bit deb, input int maxw);
    logic [W-1:0] w;
    int c, nw;
    bit have, f, r, a, b;
    w = '0; c = 0; nw = 0; have = 0; f = 0; b = 0;
    for (int k = 0; k < nt; k++) begin
      r = st[(k < n) ? k : n - 1];
      if (!deb) begin a = 1; b = r; end
      else if (!have) begin f = r; have = 1; a = 0; end
      else begin have = 0; a = (f != r); b = f; end
      if (a) begin
        w[c] = b;
        c++;
        if (c == W) begin
          if (nw < maxw) sb.push_back(w);
          nw++;
          c = 0;
        end
      end
    end
  endtask

  initial begin
    int pat[8];
    rst_n = 1'b0; en = 1'b0; debias_en = 1'b0; out_ready = 1'b0;
    ro_bits = '0; ch_mask = 4'b0001; div = 8'd1; use_rand = 1;
    pv = 1'b0; px = 1'b0; pd = '0; stab_err = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_health_fail", health_fail, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    idle(2);

    // 1: single channel, no debias, fixed pattern -> 8'h4D
    pat = '{1, 0, 1, 1, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) st[i] = bit'(pat[i]);
    ref_push(10, 8, 1'b0, 9);
    stream(8, 12, -1);
    chk("t1_latency", first_vld, 10);
    chk("t1_word", out_data, 8'h4D);
    chk("t1_health", health_fail, 0);

    // 2: debias on, all channels, pairs (0,1),(1,1),(1,0),(0,0) -> 8'hAA
    idle(1);
    ch_mask = 4'hF; debias_en = 1'b1;
    pat = '{0, 1, 1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 32; i++) st[i] = bit'(pat[i % 8]);
    ref_push(34, 32, 1'b1, 9);
    stream(32, 36, -1);
    chk("t2_word", out_data, 8'hAA);
    idle(1);
    debias_en = 1'b0;

    // 3: constant zero -> health_fail after the 32nd tick, no new words
    use_rand = 0;
    st[0] = 1'b0;
    ref_push(52, 1, 1'b0, 4);
    stream(1, 54, -1);
    chk("t3_hf_cycle", first_hf, 34);
    chk("t3_last_valid", last_vld, 34);
    chk("t3_hf_held", health_fail, 1);
    idle(2);
    chk("t3_hf_cleared", health_fail, 0);

    // 4: out_ready held low -> first word held, second parked, overrun
    use_rand = 1; ch_mask = 4'b0001;
    for (int i = 0; i < 20; i++) st[i] = bit'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) exp_b[i] = st[8 + i];
    stab_err = 0;
    ref_push(20, 20, 1'b0, 2);
    stream(20, 22, 21);
    drive(mk_ro(1'b0), 1'b0, 1'b0);
    chk("t4_ovr_cycle", first_ovr, 19);
    chk("t4_overrun", overrun, 1);
    chk("t4_reload_valid", out_valid, 1);
    chk("t4_reload_data", out_data, exp_b);
    idle(2);
    chk("t4_ovr_cleared", overrun, 0);
    chk("t4_stable", stab_err, 0);

    // 5: div 0 and 1 tick every cycle, div 3 every third cycle
    use_rand = 0; st[0] = 1'b1;
    div = 8'd0;
    ref_push(10, 1, 1'b0, 9);
    stream(1, 12, -1);
    chk("t5_div0", first_vld, 10);
    idle(1); div = 8'd1;
    ref_push(10, 1, 1'b0, 9);
    stream(1, 12, -1);
    chk("t5_div1", first_vld, 10);
    idle(1); div = 8'd3;
    ref_push(8, 1, 1'b0, 9);
    stream(1, 27, -1);
    chk("t5_div3", first_vld, 26);
    idle(1); div = 8'd1;

    // 6: async reset with a word pending and 5 bits collected
    use_rand = 1;
    for (int i = 0; i < 13; i++) st[i] = bit'($urandom_range(0, 1));
    st[0] = 1'b1;
    stream(13, 15, -2);
    @(posedge clk);
    #2;
    chk("t6_pre_valid", out_valid, 1);
    rst_n = 1'b0; en = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_health", health_fail, 0);
    chk("t6_rst_overrun", overrun, 0);
    pv = 1'b0; px = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) st[i] = bit'($urandom_range(0, 1));
    ref_push(10, 8, 1'b0, 9);
    stream(8, 12, -1);
    chk("t6_fresh_latency", first_vld, 10);

    // Drain and wrap up
    for (int i = 0; i < 20 && sb.size() != 0; i++) drive(mk_ro(1'b0), 1'b0, 1'b1);
    chk("sb_empty", sb.size(), 0);
    chk("stable_all", stab_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_ro_trng_collector
